// File: rtl/clk_freq_meter_if.sv
// Signal bundle for clk_freq_meter: the measured clock and enable in, the period report and status flags out.
interface clk_freq_meter_if #(
    parameter int NBITS = 14
);
    logic             clk_in;
    logic             enable;
    logic [NBITS-1:0] period;
    logic             period_valid;
    logic             timeout;
    logic             clk_match;

    modport master (
        output clk_in, enable,
        input  period, period_valid, timeout, clk_match
    );

    modport slave (
        input  clk_in, enable,
        output period, period_valid, timeout, clk_match
    );
endinterface

// File: rtl/clk_freq_meter.sv
// Measures the clk_in period in clk_FPGA cycles, flags loss of clock by timeout.
// Optional CLK_MATCH_EN adds a registered +/-TOL_CYCLES frequency-match flag.
module clk_freq_meter #(
    parameter int SYS_CLK_HZ     = 50000000,
    parameter int FREQUENCY      = 10000,
    parameter int EXP_PERIOD     = SYS_CLK_HZ / FREQUENCY,
    parameter int TIMEOUT_CYCLES = 2 * EXP_PERIOD,
    parameter int TOL_CYCLES     = 4,
    parameter int NBITS          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic            clk_FPGA,
    input  logic            reset,
    clk_freq_meter_if.slave bus
);
    localparam logic [NBITS-1:0] CNT_MAX = NBITS'(TIMEOUT_CYCLES);
    localparam logic [NBITS-1:0] CNT_ONE = NBITS'(1);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    state_t           state;
    logic [NBITS-1:0] cnt;
    logic [NBITS-1:0] period_q;
    logic             period_valid_q;
    logic             timeout_q;
    logic             s1, s2, s3;
    logic             rise;
    logic             at_max;

    // s1/s2 resynchronise clk_in; s3 is the delayed copy for edge detection
    always_ff @(posedge clk_FPGA or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.clk_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise   = s2 & ~s3;
    assign at_max = (cnt == CNT_MAX);

    always_ff @(posedge clk_FPGA or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            period_valid_q <= 1'b0;
            if (!bus.enable) begin
                state     <= IDLE;
                cnt       <= '0;
                timeout_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt       <= '0;
                        timeout_q <= 1'b0;
                        state     <= ARM;
                    end
                    ARM: begin
                        if (rise) begin
                            cnt   <= CNT_ONE;
                            state <= MEASURE;
                        end else if (at_max) begin
                            timeout_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    MEASURE: begin
                        // a rise coinciding with the timeout count still counts as a period
                        if (rise) begin
                            period_q       <= cnt;
                            period_valid_q <= 1'b1;
                            cnt            <= CNT_ONE;
                            timeout_q      <= 1'b0;
                        end else if (at_max) begin
                            timeout_q <= 1'b1;
                            cnt       <= '0;
                            state     <= ARM;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.period       = period_q;
    assign bus.period_valid = period_valid_q;
    assign bus.timeout      = timeout_q;

`ifdef CLK_MATCH_EN
    // one extra bit keeps EXP_PERIOD-TOL_CYCLES representable when it goes negative
    localparam logic signed [NBITS:0] MATCH_LO = (NBITS+1)'(EXP_PERIOD - TOL_CYCLES);
    localparam logic signed [NBITS:0] MATCH_HI = (NBITS+1)'(EXP_PERIOD + TOL_CYCLES);

    logic signed [NBITS:0] cnt_s;
    logic                  meas_hit;
    logic                  to_hit;
    logic                  clk_match_q;

    assign cnt_s    = $signed({1'b0, cnt});
    assign meas_hit = bus.enable && (state == MEASURE) && rise;
    assign to_hit   = bus.enable && !rise && at_max && ((state == ARM) || (state == MEASURE));

    always_ff @(posedge clk_FPGA or negedge reset) begin
        if (!reset)
            clk_match_q <= 1'b0;
        else if (!bus.enable || to_hit)
            clk_match_q <= 1'b0;
        else if (meas_hit)
            clk_match_q <= (cnt_s >= MATCH_LO) && (cnt_s <= MATCH_HI);
    end

    assign bus.clk_match = clk_match_q;
`else
    assign bus.clk_match = 1'b0;
`endif
endmodule

// File: tb/tb_clk_freq_meter.sv
// Directed, table-driven bench for clk_freq_meter at default parameters (5000-cycle expected period).
module tb_clk_freq_meter;
    logic clk_FPGA = 1'b0;
    logic reset;

    clk_freq_meter_if #(.NBITS(14)) bus();

    clk_freq_meter dut (
        .clk_FPGA (clk_FPGA),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clk_FPGA = ~clk_FPGA;

`ifdef CLK_MATCH_EN
    localparam int M = 1;
`else
    localparam int M = 0;
`endif

    typedef struct {
        int gap;      // cycles from previous clk_in rise to this one
        int exp_v;    // period_valid pulses expected after this rise
        int exp_per;
        int exp_m;
        int exp_to;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;
    int since = 0;
    int half = 0;
    int vcnt = 0;
    int dbl = 0;
    logic prev_v = 1'b0;

    always @(negedge clk_FPGA) begin
        if (bus.period_valid) begin
            vcnt++;
            if (prev_v) dbl++;
        end
        prev_v = bus.period_valid;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // clk_in only ever falls during a gap; it rises only at the end of drive_gap
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            bus.clk_in = bus.clk_in & (since < half);
            @(negedge clk_FPGA);
            since++;
        end
    endtask

    task automatic drive_gap(input int g);
        half = g / 2;
        while (since < g) step(1);
        bus.clk_in = 1'b1;
        since = 0;
    endtask

    task automatic apply_vec(input vec_t v, input string nm);
        int v0;
        drive_gap(v.gap);
        v0 = vcnt;
        step(5);
        chk({nm, "_valid"},   vcnt - v0,            v.exp_v);
        chk({nm, "_period"},  int'(bus.period),     v.exp_per);
        chk({nm, "_match"},   int'(bus.clk_match),  v.exp_m);
        chk({nm, "_timeout"}, int'(bus.timeout),    v.exp_to);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [6];
        tbl[0] = '{100,  0, 0,    0, 0};  // first rise only arms
        tbl[1] = '{5000, 1, 5000, M, 0};
        tbl[2] = '{5000, 1, 5000, M, 0};
        tbl[3] = '{5004, 1, 5004, M, 0};
        tbl[4] = '{5005, 1, 5005, 0, 0};
        tbl[5] = '{5004, 1, 5004, M, 0};

        reset = 1'b0;
        bus.enable = 1'b1;
        bus.clk_in = 1'b0;
        step(3);
        chk("rst_period",  int'(bus.period),       0);
        chk("rst_valid",   int'(bus.period_valid), 0);
        chk("rst_timeout", int'(bus.timeout),      0);
        chk("rst_match",   int'(bus.clk_match),    0);
        reset = 1'b1;
        since = 0;

        for (int i = 0; i < 6; i++) apply_vec(tbl[i], $sformatf("t1_%0d", i));

        // clock stops: timeout exactly 10000 cycles after the rise (rise seen 3 cycles after drive)
        begin
            int v0;
            v0 = vcnt;
            while (since < 10002) step(1);
            chk("t3_timeout_early", int'(bus.timeout), 0);
            step(1);
            chk("t3_timeout_exact", int'(bus.timeout), 1);
            chk("t3_period_held",   int'(bus.period), 5004);
            chk("t3_match_clr",     int'(bus.clk_match), 0);
            chk("t3_no_valid",      vcnt - v0, 0);
        end
        apply_vec('{10100, 0, 5004, 0, 1}, "t3_rearm");
        apply_vec('{5000,  1, 5000, M, 0}, "t3_resume");

        // enable dropped mid-period
        step(1000 - since);
        bus.enable = 1'b0;
        step(1);
        chk("t4_timeout", int'(bus.timeout), 0);
        chk("t4_match",   int'(bus.clk_match), 0);
        chk("t4_period",  int'(bus.period), 5000);
        apply_vec('{5000, 0, 5000, 0, 0}, "t4_disabled");
        bus.enable = 1'b1;
        apply_vec('{5000, 0, 5000, 0, 0}, "t4_rearm");
        apply_vec('{5000, 1, 5000, M, 0}, "t4_resume");

        // asynchronous reset between clock edges
        step(1000 - since);
        bus.clk_in = 1'b0;
        step(10);
        #2 reset = 1'b0;
        #1;
        chk("t5_period",  int'(bus.period),       0);
        chk("t5_valid",   int'(bus.period_valid), 0);
        chk("t5_timeout", int'(bus.timeout),      0);
        chk("t5_match",   int'(bus.clk_match),    0);
        step(3);
        reset = 1'b1;
        apply_vec('{1200, 0, 0,    0, 0}, "t5_arm");
        apply_vec('{5000, 1, 5000, M, 0}, "t5_resume");

        // timeout boundary: 10000 is a period, 10001 is a timeout
        apply_vec('{10000, 1, 10000, 0, 0}, "t6_edge");
        apply_vec('{10001, 0, 10000, 0, 1}, "t6_late");

        chk("no_back_to_back_valid", dbl, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/clk_freq_meter.md
Name: clk_freq_meter

Overview:
- Measures the period of an incoming slow clock `clk_in`, counted in `clk_FPGA` cycles.
- `clk_in` typically comes from a clock-generator output, an external pin or a peer board.
- This is the measuring counterpart of the team's clock divider: the divider produces a clock of a given FREQUENCY, and this block checks a clock against that FREQUENCY.
- Reports each completed period with a one-cycle valid strobe, flags loss of clock by timeout, and optionally flags a frequency match.

Parameters:
- SYS_CLK_HZ, 50000000, frequency of clk_FPGA in Hz.
- FREQUENCY, 10000, expected clk_in frequency in Hz.
- EXP_PERIOD, SYS_CLK_HZ/FREQUENCY (5000), expected period in clk_FPGA cycles; integer division.
- TIMEOUT_CYCLES, 2*EXP_PERIOD (10000), cycles with no rising edge before timeout is declared.
- TOL_CYCLES, 4, match tolerance in cycles, +/- around EXP_PERIOD.
- NBITS, ceil(log2(TIMEOUT_CYCLES+1)) (14), width of the counter and of `period`.

Ports:
- clk_FPGA  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- clk_in  input  1  clock under measurement; asynchronous to clk_FPGA.
- enable  input  1  1 = measure, 0 = idle/clear.
- period  output  NBITS  last measured period in clk_FPGA cycles.
- period_valid  output  1  one-cycle pulse when `period` updates.
- timeout  output  1  sticky loss-of-clock flag.
- clk_match  output  1  period within tolerance (see Optional Feature).

Behaviour:
- Interface: reset is asynchronous, active-low; clock is clk_FPGA.
- Reset values: period=0, period_valid=0, timeout=0, clk_match=0, FSM=IDLE, cnt=0, synchronizer flops=0.
- Synchronization and edge detect:
  - clk_in passes through a 2-flop synchronizer (s1, s2), then a third flop s3.
  - rise = s2 & ~s3.
  - Fixed latency of 2–3 cycles from clk_in edge to rise; the offset cancels in the period.
- Input constraint: clk_in high and low phases are each >= 2 clk_FPGA cycles. Faster inputs are unsupported and produce no defined result.
- cnt: NBITS wide, saturates at TIMEOUT_CYCLES and never wraps.
- FSM states:
  - IDLE: cnt=0; timeout and clk_match cleared; period held. If enable=1, go to ARM next cycle.
  - ARM: waits for the first rise. cnt increments, saturating.
    - If cnt reaches TIMEOUT_CYCLES: set timeout=1 and stay in ARM.
    - On rise: cnt<=1, go to MEASURE; no period is reported.
  - MEASURE: cnt increments each cycle.
    - On rise: period<=cnt, period_valid=1 for exactly the next cycle (registered), cnt<=1, timeout<=0, stay in MEASURE.
    - If cnt reaches TIMEOUT_CYCLES with no rise: timeout<=1, cnt<=0, go to ARM. The next rise only re-arms; no bogus period is reported.
  - In any state, enable=0 forces IDLE on the next cycle, with no period_valid.
- Period definition: rises at cycles t0 and t1 give period = t1 - t0.
- Simultaneous rise and cnt==TIMEOUT_CYCLES in MEASURE: the rise wins. period=TIMEOUT_CYCLES, valid is pulsed, timeout is not set.
- Reset release with clk_in high: the synchronizer produces an immediate rise. It acts only as the ARM edge and is harmless.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously).
- period_valid is never asserted on two consecutive cycles (minimum period 4).

Optional Feature:
- Macro: CLK_MATCH_EN.
- Defined:
  - clk_match is registered and updated together with each period_valid.
  - clk_match = 1 iff EXP_PERIOD-TOL_CYCLES <= period <= EXP_PERIOD+TOL_CYCLES.
  - The comparison uses NBITS+1 signed-safe arithmetic, with no underflow when TOL_CYCLES > EXP_PERIOD.
  - Cleared on timeout assertion, enable=0 and reset.
- Not defined: the port remains present and is tied to 0; no comparator logic is synthesized.

Test Plan:
1. reset, enable=1, clk_in 10 kHz (2500 high / 2500 low) -> no valid on the first rise; from the second rise on, period=5000 with period_valid pulses every 5000 cycles; timeout=0; clk_match=1 (with CLK_MATCH_EN).
2. clk_in period 5004 then 5005 cycles -> period=5004 with clk_match=1, then period=5005 with clk_match=0; without the macro, clk_match stays 0.
3. Stop clk_in after a valid -> timeout=1 exactly 10000 cycles after the last rise; period holds its old value; clk_match=0. Restart clk_in -> first rise gives no valid; second rise gives valid and timeout=0.
4. enable dropped 1000 cycles into a period -> no period_valid; timeout=0 and clk_match=0 the next cycle; period held. Re-enable -> re-arms, first valid after two rises.
5. reset asserted mid-MEASURE, asynchronously between clock edges -> all outputs 0 immediately; after release, behaves as at power-up.
6. Rises spaced exactly 10000 cycles -> period=10000 with period_valid, timeout stays 0; spacing 10001 -> timeout=1 and no valid on the late rise.
